// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment display blocks: the glyph table,
// the segment bit order and the "dark" values for segments and digit selects.
package sevseg_pkg;

  // Widest display bank the scan driver supports.
  localparam int MAX_DIGITS = 8;

  // Segment bit order inside the 7-bit {a,b,c,d,e,f,g} vector.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // All segments off, and all digit selects inactive (active-low selects).
  localparam logic [6:0]            SEG_OFF = 7'b0000000;
  localparam logic [MAX_DIGITS-1:0] SEL_OFF = '1;

  // Highest code that is a plain decimal digit.
  localparam logic [3:0] LAST_DEC_CODE = 4'd9;

  // Glyphs for codes 0..15; entry n is GLYPH_TABLE[n]. Codes 10..15 hold the
  // hex letters A, b, C, d, E, F so that one table serves both builds.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  // Raw table lookup, without any decision about how codes 10..15 render.
  function automatic logic [6:0] glyph_lookup(input logic [3:0] code);
    return GLYPH_TABLE[code];
  endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational 4-bit code to {a,b,c,d,e,f,g} glyph decoder.
// Define SEVSEG_HEX_EN to render codes 10..15 as A b C d E F; without it
// those codes render as a blank digit.
module seven_seg_glyph
  import sevseg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  // Table lookup; the non-decimal codes are either shown as hex or blanked.
  always_comb begin
`ifdef SEVSEG_HEX_EN
    glyph = glyph_lookup(code);
`else
    glyph = (code > LAST_DEC_CODE) ? SEG_OFF : glyph_lookup(code);
`endif
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a DIGITS-wide seven-segment display bank.
// One digit is lit at a time for DIV clock cycles. Inputs are captured once
// per frame, on the edge that lights digit 0, so a frame never tears.
// Optional build macro: SEVSEG_HEX_EN (hex letters for codes 10..15,
// handled inside seven_seg_glyph).
module seven_seg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_start
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_DARK   = SEL_OFF[DIGITS-1:0];
  localparam logic [DIGITS-1:0] SEL_ONE    = DIGITS'(1);

  logic [PW-1:0]       presc;
  logic                tick;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_next;
  logic                wrap;

  logic [4*DIGITS-1:0] snap_data;
  logic [DIGITS-1:0]   snap_dp;
  logic                snap_blz;

  logic [4*DIGITS-1:0] view_data;
  logic [DIGITS-1:0]   view_dp;
  logic                view_blz;

  logic [3:0]          digit_codes [DIGITS];
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;

  logic [3:0]          cur_code;
  logic [6:0]          cur_glyph;
  logic [6:0]          seg_next;
  logic [DIGITS-1:0]   sel_next;
  logic                dp_next;

  assign tick = (presc == PRESC_LAST);

  // Prescaler: counts 0..DIV-1 and wraps; its terminal count is the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Digit index that the coming tick will light, wrapping after the last digit.
  always_comb begin
    idx_next = '0;
    if (idx != IDX_LAST) begin
      idx_next = idx + 1'b1;
    end
  end

  assign wrap = tick && (idx_next == '0);

  // Index register; starts on the last digit so the first tick lands on digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= IDX_LAST;
    end else if (tick) begin
      idx <= idx_next;
    end
  end

  // Frame snapshot, taken only on the edge that lights digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_data <= '0;
      snap_dp   <= '0;
      snap_blz  <= 1'b0;
    end else if (wrap) begin
      snap_data <= data;
      snap_dp   <= dp;
      snap_blz  <= blank_lz;
    end
  end

  // Values the outgoing digit is rendered from: on a frame edge digit 0 must
  // show the freshly captured inputs, otherwise the held snapshot.
  always_comb begin
    view_data = wrap ? data     : snap_data;
    view_dp   = wrap ? dp       : snap_dp;
    view_blz  = wrap ? blank_lz : snap_blz;
  end

  // Split the packed digit vector into per-digit codes.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      digit_codes[i] = view_data[4*i +: 4];
    end
  end

  // Leading-zero mask: walk down from the top digit while codes are zero;
  // digit 0 is never part of the mask and any nonzero code ends the run.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (digit_codes[i] == 4'd0);
      lz_mask[i] = view_blz & zero_run;
    end
  end

  assign cur_code = digit_codes[idx_next];

  seven_seg_glyph u_glyph (
    .code  (cur_code),
    .glyph (cur_glyph)
  );

  // Next output values for the digit the coming tick lights.
  always_comb begin
    seg_next = lz_mask[idx_next] ? SEG_OFF : cur_glyph;
    sel_next = ~(SEL_ONE << idx_next);
    dp_next  = view_dp[idx_next];
  end

  // Registered display outputs: updated on ticks, dark until the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg    <= SEG_OFF;
      seg_dp <= 1'b0;
      sel    <= SEL_DARK;
    end else if (tick) begin
      seg    <= seg_next;
      seg_dp <= dp_next;
      sel    <= sel_next;
    end
  end

  // Frame-start pulse: high only for the cycle after digit 0 is lit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
    end
  end

endmodule
